// File: rtl/mcs4_fetch_sequencer.sv
// rtl/mcs4_fetch_sequencer.sv - MCS-4 ROM bus master: phase clocks, SYNC, 8-subcycle fetch
module mcs4_fetch_sequencer #(
  parameter int PHASE_LEN = 2,
  parameter int IDLE_GAP  = 1
) (
  input  logic        clk_i,
  input  logic        RESET_i,
  input  logic        req_i,
  input  logic [11:0] addr_i,
  output logic        ack_o,
  output logic [7:0]  data_o,
  output logic        busy_o,
  output logic [2:0]  cycle_o,
  output logic        PHI1_o,
  output logic        PHI2_o,
  output logic        SYNC_o,
  output logic        CM_o,
  inout  wire  [3:0]  D_io
);

  localparam int PW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(PHASE_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(IDLE_GAP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  logic [1:0]    quarter;
  logic [PW-1:0] phase_cnt;
  logic          boundary;

  state_t        state, state_d;
  logic [2:0]    cycle, cycle_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic          accept;
  logic [11:0]   addr_q;
  logic          drive_en;
  logic [3:0]    bus_nib;

  // Free-running quarter/phase counter; PHI1 in Q1, PHI2 in Q3, so they can never overlap.
  always_ff @(posedge clk_i or posedge RESET_i) begin
    if (RESET_i) begin
      quarter   <= 2'd0;
      phase_cnt <= '0;
    end else if (phase_cnt == PHASE_LAST) begin
      phase_cnt <= '0;
      quarter   <= quarter + 2'd1;
    end else begin
      phase_cnt <= phase_cnt + PW'(1);
    end
  end

  assign boundary = (quarter == 2'd3) && (phase_cnt == PHASE_LAST);
  assign PHI1_o   = (quarter == 2'd1);
  assign PHI2_o   = (quarter == 2'd3);

  // State, subcycle index, gap count and latched fetch address.
  always_ff @(posedge clk_i or posedge RESET_i) begin
    if (RESET_i) begin
      state   <= IDLE;
      cycle   <= 3'd0;
      gap_cnt <= '0;
      addr_q  <= 12'd0;
    end else begin
      state   <= state_d;
      cycle   <= cycle_d;
      gap_cnt <= gap_d;
      if (accept) begin
        addr_q <= addr_i;
      end
    end
  end

  // Everything advances only on subcycle boundaries; the boundary ending the gap doubles as an IDLE sample point.
  always_comb begin
    state_d = state;
    cycle_d = cycle;
    gap_d   = gap_cnt;
    accept  = 1'b0;
    if (boundary) begin
      case (state)
        IDLE: begin
          if (req_i) begin
            accept  = 1'b1;
            state_d = RUN;
            cycle_d = 3'd0;
          end
        end
        RUN: begin
          if (cycle == 3'd7) begin
            state_d = GAP;
            cycle_d = 3'd0;
            gap_d   = '0;
          end else begin
            cycle_d = cycle + 3'd1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_d = '0;
            if (req_i) begin
              accept  = 1'b1;
              state_d = RUN;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_d = gap_cnt + GW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cycle_d = 3'd0;
          gap_d   = '0;
        end
      endcase
    end
  end

  assign busy_o  = (state != IDLE);
  assign SYNC_o  = (state == RUN);
  assign cycle_o = cycle;
  assign CM_o    = SYNC_o && (cycle == 3'd2);

  // ROM word arrives high nibble in M1, low nibble in M2; ack lands on the first clock of X1.
  always_ff @(posedge clk_i or posedge RESET_i) begin
    if (RESET_i) begin
      data_o <= 8'd0;
      ack_o  <= 1'b0;
    end else begin
      ack_o <= boundary && (state == RUN) && (cycle == 3'd4);
      if (boundary && (state == RUN) && (cycle == 3'd3)) begin
        data_o[7:4] <= D_io;
      end
      if (boundary && (state == RUN) && (cycle == 3'd4)) begin
        data_o[3:0] <= D_io;
      end
    end
  end

  // Address nibble for the current A subcycle; bus is released everywhere else.
  always_comb begin
    bus_nib = 4'd0;
    case (cycle)
      3'd0:    bus_nib = addr_q[3:0];
      3'd1:    bus_nib = addr_q[7:4];
      3'd2:    bus_nib = addr_q[11:8];
      default: bus_nib = 4'd0;
    endcase
  end

  assign drive_en = SYNC_o && (cycle <= 3'd2);
  assign D_io     = drive_en ? bus_nib : 4'bzzzz;

endmodule

// File: tb/tb_mcs4_fetch_sequencer.sv
// tb/tb_mcs4_fetch_sequencer.sv - scoreboard bench for mcs4_fetch_sequencer
module tb_mcs4_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_a, req_b;
  logic [11:0] addr_a, addr_b;
  logic        ack_a, ack_b;
  logic [7:0]  data_a, data_b;
  logic        busy_a, busy_b;
  logic [2:0]  cyc_a, cyc_b;
  logic        phi1_a, phi2_a, sync_a, cm_a;
  logic        phi1_b, phi2_b, sync_b, cm_b;
  wire  [3:0]  d_a, d_b;

  mcs4_fetch_sequencer #(.PHASE_LEN(2), .IDLE_GAP(1)) dut_a (
    .clk_i(clk), .RESET_i(rst), .req_i(req_a), .addr_i(addr_a),
    .ack_o(ack_a), .data_o(data_a), .busy_o(busy_a), .cycle_o(cyc_a),
    .PHI1_o(phi1_a), .PHI2_o(phi2_a), .SYNC_o(sync_a), .CM_o(cm_a), .D_io(d_a)
  );

  mcs4_fetch_sequencer #(.PHASE_LEN(1), .IDLE_GAP(3)) dut_b (
    .clk_i(clk), .RESET_i(rst), .req_i(req_b), .addr_i(addr_b),
    .ack_o(ack_b), .data_o(data_b), .busy_o(busy_b), .cycle_o(cyc_b),
    .PHI1_o(phi1_b), .PHI2_o(phi2_b), .SYNC_o(sync_b), .CM_o(cm_b), .D_io(d_b)
  );

  // ROM models: latch the address seen on the bus in A1..A3, answer in M1/M2.
  function automatic logic [7:0] rom_word(input logic [11:0] a);
    return a[7:0] ^ 8'h62;
  endfunction

  logic [11:0] rom_addr_a = 12'd0;
  logic [11:0] rom_addr_b = 12'd0;
  logic [7:0]  rw_a, rw_b;

  always @(posedge clk) if (sync_a && cyc_a < 3'd3) rom_addr_a[cyc_a*4 +: 4] <= d_a;
  always @(posedge clk) if (sync_b && cyc_b < 3'd3) rom_addr_b[cyc_b*4 +: 4] <= d_b;

  assign rw_a = rom_word(rom_addr_a);
  assign rw_b = rom_word(rom_addr_b);
  assign d_a = (sync_a && cyc_a == 3'd3) ? rw_a[7:4] : (sync_a && cyc_a == 3'd4) ? rw_a[3:0] : 4'bzzzz;
  assign d_b = (sync_b && cyc_b == 3'd3) ? rw_b[7:4] : (sync_b && cyc_b == 3'd4) ? rw_b[3:0] : 4'bzzzz;

  typedef struct {
    int          s;
    logic [11:0] a;
    logic [7:0]  w;
  } fetch_t;

  fetch_t     starts_a[$];
  fetch_t     starts_b[$];
  logic [7:0] sb_a[$];
  logic [7:0] sb_b[$];

  int checks = 0;
  int errors = 0;
  int clk_count = 0;
  int base = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) clk_count <= clk_count + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected {phi1,phi2,sync,cm,busy,ack,cycle[2:0],d[3:0]} at clock t for a fetch starting A1 at f.s.
  function automatic logic [12:0] expect_vec(input int t, input int pl, input int ig,
                                             input fetch_t f, input bit has);
    int sub, d, q;
    logic [2:0] c;
    logic [3:0] dv;
    logic sy, cmv, bz, ak;
    sub = 4 * pl;
    q = (t / pl) % 4;
    sy = 1'b0; cmv = 1'b0; bz = 1'b0; ak = 1'b0; c = 3'd0; dv = 4'bzzzz;
    if (has) begin
      d = t - f.s;
      if (d >= 0 && d < 8 * sub) begin
        sy  = 1'b1;
        bz  = 1'b1;
        c   = 3'(d / sub);
        cmv = (c == 3'd2);
        ak  = (d == 5 * sub);
        case (c)
          3'd0:    dv = f.a[3:0];
          3'd1:    dv = f.a[7:4];
          3'd2:    dv = f.a[11:8];
          3'd3:    dv = f.w[7:4];
          3'd4:    dv = f.w[3:0];
          default: dv = 4'bzzzz;
        endcase
      end else if (d >= 0 && d < (8 + ig) * sub) begin
        bz = 1'b1;
      end
    end
    return {(q == 1), (q == 3), sy, cmv, bz, ak, c, dv};
  endfunction

  // Timeline checker: every clock, compare control outputs and bus against the hand-scheduled fetches.
  always begin
    int t;
    fetch_t f;
    bit has;
    logic [12:0] e;
    @(negedge clk);
    #1;
    if (chk_en) begin
      t = clk_count - base;
      has = 1'b0;
      f = '{s: 0, a: 12'd0, w: 8'd0};
      foreach (starts_a[i]) if (starts_a[i].s <= t) begin f = starts_a[i]; has = 1'b1; end
      e = expect_vec(t, 2, 1, f, has);
      check($sformatf("a_ctl t=%0d", t), {23'd0, phi1_a, phi2_a, sync_a, cm_a, busy_a, ack_a, cyc_a}, {23'd0, e[12:4]});
      check($sformatf("a_bus t=%0d", t), {28'd0, d_a}, {28'd0, e[3:0]});
      has = 1'b0;
      f = '{s: 0, a: 12'd0, w: 8'd0};
      foreach (starts_b[i]) if (starts_b[i].s <= t) begin f = starts_b[i]; has = 1'b1; end
      e = expect_vec(t, 1, 3, f, has);
      check($sformatf("b_ctl t=%0d", t), {23'd0, phi1_b, phi2_b, sync_b, cm_b, busy_b, ack_b, cyc_b}, {23'd0, e[12:4]});
      check($sformatf("b_bus t=%0d", t), {28'd0, d_b}, {28'd0, e[3:0]});
    end
  end

  // Scoreboard monitor: each ack pops one expected word.
  always begin
    @(negedge clk);
    #1;
    if (ack_a) begin
      if (sb_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_data unexpected ack actual=%h required=none", data_a);
      end else begin
        check("a_data", {24'd0, data_a}, {24'd0, sb_a.pop_front()});
      end
    end
    if (ack_b) begin
      if (sb_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_data unexpected ack actual=%h required=none", data_b);
      end else begin
        check("b_data", {24'd0, data_b}, {24'd0, sb_b.pop_front()});
      end
    end
  end

  task automatic wait_t(input int tt);
    while (clk_count - base < tt) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_a_out"}, {15'd0, phi1_a, phi2_a, sync_a, cm_a, busy_a, ack_a, cyc_a, data_a}, 32'd0);
    check({tag, "_a_bus"}, {28'd0, d_a}, {28'd0, 4'bzzzz});
    check({tag, "_b_out"}, {15'd0, phi1_b, phi2_b, sync_b, cm_b, busy_b, ack_b, cyc_b, data_b}, 32'd0);
    check({tag, "_b_bus"}, {28'd0, d_b}, {28'd0, 4'bzzzz});
  endtask

  initial begin
    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    addr_a = 12'd0; addr_b = 12'd0;
    repeat (3) @(negedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    base = clk_count;
    chk_en = 1'b1;

    wait_t(2);
    addr_b = 12'h25B; req_b = 1'b1;
    starts_b.push_back('{s: 4,  a: 12'h25B, w: 8'h39});
    starts_b.push_back('{s: 48, a: 12'h25B, w: 8'h39});
    sb_b.push_back(8'h39);
    sb_b.push_back(8'h39);

    wait_t(18);
    addr_a = 12'h3A5; req_a = 1'b1;
    starts_a.push_back('{s: 24, a: 12'h3A5, w: 8'hC7});
    sb_a.push_back(8'hC7);
    wait_t(25);
    req_a = 1'b0;
    wait_t(34);
    addr_a = 12'h0F0;

    wait_t(50);
    req_b = 1'b0;

    wait_t(66);
    addr_a = 12'h1C8; req_a = 1'b1;
    starts_a.push_back('{s: 96,  a: 12'h1C8, w: 8'hAA});
    starts_a.push_back('{s: 168, a: 12'h1C8, w: 8'hAA});
    sb_a.push_back(8'hAA);
    sb_a.push_back(8'hAA);
    wait_t(170);
    req_a = 1'b0;

    wait_t(242);
    addr_a = 12'h0F0; req_a = 1'b1;
    wait_t(245);
    req_a = 1'b0;

    wait_t(250);
    addr_a = 12'h7E4; req_a = 1'b1;
    starts_a.push_back('{s: 256, a: 12'h7E4, w: 8'h86});

    wait_t(283);
    rst = 1'b1;
    chk_en = 1'b0;
    starts_a.delete();
    starts_b.delete();
    sb_a.delete();
    #1;
    check_reset("abort");
    repeat (3) @(negedge clk);
    #1;
    check_reset("hold");
    @(negedge clk);
    rst = 1'b0;
    base = clk_count;
    starts_a.push_back('{s: 8, a: 12'h7E4, w: 8'h86});
    sb_a.push_back(8'h86);
    chk_en = 1'b1;
    wait_t(9);
    req_a = 1'b0;
    wait_t(100);
    chk_en = 1'b0;

    check("a_sb_drained", sb_a.size(), 32'd0);
    check("b_sb_drained", sb_b.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcs4_fetch_sequencer.md
Name: mcs4_fetch_sequencer

Overview:
- Bus master for the MCS-4 ROM bus. Generates the two-phase clocks (PHI1/PHI2) and SYNC, and sequences the 8-subcycle instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3).
- Drives a 12-bit fetch address onto D[3:0] during A1–A3 and captures the 8-bit ROM word during M1/M2.
- Returns that word to a single requester over a req/ack handshake. Sits between the fetch logic and one or more i4001 ROM instances on the shared D bus.

Parameters:
PHASE_LEN, 2, clk_i cycles per quarter-subcycle (≥1); one subcycle = 4*PHASE_LEN clocks
IDLE_GAP, 1, whole subcycles with SYNC low after X3 before the next cycle may start (≥1)

Ports:
clk_i  input  1  main design clock
RESET_i  input  1  reset, asynchronous, active-high
req_i  input  1  fetch request; held high until ack_o
addr_i  input  12  fetch address: [3:0] in A1, [7:4] in A2, [11:8] in A3
ack_o  output  1  one-clock pulse; data_o valid in the same clock
data_o  output  8  fetched word {M1 nibble, M2 nibble}
busy_o  output  1  high from request accept through end of the gap
cycle_o  output  3  current subcycle index (A1=0 … X3=7); 0 when idle
PHI1_o  output  1  clock phase 1 to ROMs
PHI2_o  output  1  clock phase 2 to ROMs
SYNC_o  output  1  high for the whole active instruction cycle
CM_o  output  1  memory control, high during A3 only
D_io  inout  4  shared data bus

Behaviour:
- Reset (async, active-high): all outputs to 0, D_io tri-stated, FSM to IDLE, quarter counter to Q0. A request pending at reset is dropped with no ack.
- Reset mid-cycle aborts the cycle immediately. After release, req_i is re-evaluated from IDLE.
- Phase generator:
  - Free-runs at all times outside reset. Quarters Q0..Q3, each PHASE_LEN clocks.
  - Q0 and Q2: both phases low. Q1: PHI1_o high. Q3: PHI2_o high.
  - PHI1_o and PHI2_o are never high together.
  - A subcycle boundary is the last clock of Q3.
- FSM states IDLE, RUN, GAP:
  - IDLE: req_i is sampled on the subcycle-boundary clock. If high, latch addr_i, set busy_o, and go to RUN with cycle=0 at the next clock. SYNC_o rises in that same clock.
  - RUN: cycle_o increments at each subcycle boundary. After cycle 7 ends, go to GAP: SYNC_o falls and cycle_o returns to 0.
  - GAP: lasts IDLE_GAP subcycles, then go to IDLE and clear busy_o. req_i is ignored during RUN and GAP.
- Bus drive:
  - D_io is driven only in subcycles A1, A2, A3, with the latched nibbles addr[3:0], addr[7:4], addr[11:8] respectively.
  - D_io is tri-stated in all other subcycles and in IDLE/GAP.
  - CM_o is high exactly during subcycle A3.
- Capture: D_io is sampled on the last clock of Q3 in M1 (data_o[7:4]) and M2 (data_o[3:0]).
- Ack: ack_o pulses for one clock on the first clock of X1. data_o holds its value until the next capture.
- Latency: first clock of A1 to ack_o = 5 subcycles = 20*PHASE_LEN clocks.
- Throughput: one fetch per (8+IDLE_GAP) subcycles.
- Boundaries:
  - req_i dropped before accept: no cycle starts.
  - req_i dropped after accept: the cycle completes and ack_o is still issued.
  - req_i held high after ack_o: treated as a new request at the first IDLE boundary.
  - addr_i changes after accept: ignored; the latched copy is used.

Test Plan:
- Reset then idle, PHASE_LEN=2 → PHI1_o high clocks 2–3 and PHI2_o high clocks 6–7 of every 8; never overlapping; SYNC_o, CM_o, busy_o stay 0; D_io=z.
- req_i with addr_i=12'h3A5, ROM returns 0xC7 → D_io drives 5, A, 3 in A1/A2/A3; CM_o high only in A3; ack_o at A1+40 clocks; data_o=8'hC7.
- Two back-to-back requests with IDLE_GAP=1 → SYNC_o low for exactly 8 clocks between cycles; second A1 starts 72 clocks after the first.
- RESET_i asserted during M1 → all outputs 0 and D_io=z immediately; no ack_o; after release with req_i high, a full cycle runs and data is correct.
- req_i raised mid-subcycle in IDLE → SYNC_o rises only the clock after the next Q3 end; addr_i changed during A2 → bus still shows the latched nibbles.
- PHASE_LEN=1, IDLE_GAP=3 → subcycle = 4 clocks; ack_o 20 clocks after SYNC_o rises; gap = 12 clocks with SYNC_o low.
